// File: rtl/serial_sub_unit_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package serial_sub_unit_pkg;

  localparam int unsigned AluW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_unit_sub_bit.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module serial_sub_unit_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor, LSB first, one bit per clock with a start/done handshake.
// Optional signed-overflow flag via SERIAL_SUB_OVF_EN.
module serial_sub_unit
  import serial_sub_unit_pkg::*;
#(
  parameter int unsigned WIDTH = AluW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] sd_shift;

  serial_sub_unit_sub_bit u_sub_bit (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Result register with the current bit already inserted at the MSB.
  assign sd_shift = (sd_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      StRun: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_shift;
        br_d  = bit_bout;
        cnt_d = cnt_q + CntW'(1);
        // Publish on the last bit so the result is already valid while done is high.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          diff_d   = sd_shift;
          borrow_d = bit_bout;
          zero_d   = (sd_shift == '0);
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (sd_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit (WIDTH=8): directed cases plus randomized operands.
module tb_serial_sub_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub_unit #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    exp_t e;
    int   du;
    int   ds;
    du       = int'(x) - int'(y);
    ds       = int'($signed(x)) - int'($signed(y));
    e.diff   = du[W-1:0];
    e.borrow = (du < 0);
    e.zero   = (e.diff == 0);
    e.ovf    = (ds > 127) || (ds < -128);
    e.cyc    = c;
    return e;
  endfunction

  // Monitor: checks reset state, completed results and output hold between results.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", {22'd0, borrow, zero, diff}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    end else if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("borrow", 32'(borrow), 32'(e.borrow));
        chk("zero", 32'(zero), 32'(e.zero));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd1);
        held = e;
      end
    end else begin
      chk("hold", {22'd0, borrow, zero, diff}, {22'd0, held.borrow, held.zero, held.diff});
`ifdef SERIAL_SUB_OVF_EN
      chk("hold_ovf", 32'(ovf), 32'(held.ovf));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    q.push_back(model(x, y, cyc + W));
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 4 * W;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    held  = '{diff: '0, borrow: 1'b0, zero: 1'b0, ovf: 1'b0, cyc: 0};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    launch(8'h35, 8'h12); wait_idle();
    launch(8'h00, 8'h01); wait_idle();
    launch(8'hA5, 8'hA5); wait_idle();

    // Start while busy must be ignored.
    launch(8'h10, 8'h01);
    step();
    step();
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_ignored_start", 32'(busy), 32'd1);
    wait_idle();

    // Mid-run reset aborts without a done pulse.
    launch(8'h44, 8'h22);
    repeat (3) step();
    rst_n = 1'b0;
    q.delete();
    held = '{diff: '0, borrow: 1'b0, zero: 1'b0, ovf: 1'b0, cyc: 0};
    step();
    rst_n = 1'b1;
    repeat (W + 3) step();
    launch(8'h35, 8'h12); wait_idle();

    launch(8'h80, 8'h01); wait_idle();
    launch(8'h7F, 8'hFF); wait_idle();
    launch(8'h05, 8'h03); wait_idle();

    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
      launch(x, y);
      for (int i = 0; i < W - 1; i++) begin
        a     = W'($urandom);
        b     = W'($urandom);
        start = 1'($urandom_range(0, 1));
        step();
      end
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
